// File: rtl/mux_pkg.sv
// Shared types and constants for the 4-lane stream multiplexer.
// Lane count, select width, arbiter state and a one-hot helper.
package mux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } mux_state_t;

    function automatic logic [LANES-1:0] onehot(input logic [SEL_W-1:0] idx);
        return LANES'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching ptr, ptr+1, ... with 2-bit wrap.
module rr_pick4
    import mux_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [LANES-1:0] w_rot;
    logic [SEL_W-1:0] w_off;

    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    always_comb begin
        w_rot = '0;
        w_off = '0;
        for (int i = 0; i < LANES; i++) begin
            w_rot[i] = req[SEL_W'(i) + ptr];
        end
        // Scan downwards so the lowest rotated position wins.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    assign gnt_idx = w_off + ptr;
    assign gnt_any = |req;

endmodule

// File: rtl/mux4x1_stream.sv
// Four valid/ready lanes merged into one registered stream tagged with its
// source lane; round-robin between packets, packets never interleave.
module mux4x1_stream
    import mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES-1:0]        in_last,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic [LANES-1:0]        in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_last
);

    mux_state_t         r_state;
    mux_state_t         w_state_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_lock;

    logic               w_load;
    logic [SEL_W-1:0]   w_gnt_idx;
    logic               w_gnt_any;
    logic [SEL_W-1:0]   w_sel;
    logic               w_accept;
    logic               w_sel_last;
    logic [DATA_W-1:0]  w_sel_data;

    rr_pick4 u_pick (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    assign w_load = !out_valid || out_ready;

    always_comb begin
        in_ready    = '0;
        w_sel       = r_lock;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                w_sel = w_gnt_idx;
                if (w_load && w_gnt_any) begin
                    in_ready = onehot(w_gnt_idx);
                end
            end
            BURST: begin
                // The locked lane is offered the slot even across gaps.
                if (w_load) begin
                    in_ready = onehot(r_lock);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_accept   = |(in_valid & in_ready);
        w_sel_last = in_last[w_sel];
        w_sel_data = in_data[w_sel*DATA_W +: DATA_W];

        if (w_accept) begin
            w_state_nxt = w_sel_last ? IDLE : BURST;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_lock    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                out_valid <= 1'b1;
                out_data  <= w_sel_data;
                out_sel   <= w_sel;
                out_last  <= w_sel_last;
                r_lock    <= w_sel;
                // Packet end: the finishing lane drops to lowest priority.
                if (w_sel_last) begin
                    r_ptr <= w_sel + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux4x1_stream.sv
// Self-checking bench for mux4x1_stream: directed scenarios followed by
// random traffic, all compared against a packet-level reference model.
module tb_mux4x1_stream;

    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          in_valid;
    logic [3:0]          in_last;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                out_last;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: held beat, lane owning an open packet (-1 if none),
    // and the lane that has first claim on the next packet.
    logic        m_valid;
    logic [7:0]  m_data;
    int          m_sel;
    logic        m_last;
    int          m_lock;
    int          m_ptr;

    mux4x1_stream #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] model_ready();
        if (m_valid && !out_ready) return 4'b0000;
        if (m_lock >= 0) return 4'(1 << m_lock);
        for (int k = 0; k < 4; k++) begin
            int l;
            l = (m_ptr + k) % 4;
            if (in_valid[l]) return 4'(1 << l);
        end
        return 4'b0000;
    endfunction

    task automatic model_edge(input logic [3:0] rdy);
        logic [3:0] acc;
        if (rst) begin
            m_valid = 1'b0; m_data = 8'h00; m_sel = 0; m_last = 1'b0;
            m_lock  = -1;   m_ptr  = 0;
            return;
        end
        acc = rdy & in_valid;
        if (acc != 4'b0000) begin
            for (int l = 0; l < 4; l++) begin
                if (acc[l]) begin
                    m_valid = 1'b1;
                    m_data  = in_data[l*8 +: 8];
                    m_sel   = l;
                    m_last  = in_last[l];
                    if (in_last[l]) begin
                        m_lock = -1;
                        m_ptr  = (l + 1) % 4;
                    end else begin
                        m_lock = l;
                    end
                end
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: check the combinational accept vector, clock, then check outputs.
    task automatic tick();
        logic [3:0] exp_rdy;
        #3;
        exp_rdy = model_ready();
        if (!rst) check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        model_edge(exp_rdy);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_sel",   32'(out_sel),   32'(m_sel));
        check("out_last",  32'(out_last),  32'(m_last));
    endtask

    task automatic set_lane(input int l, input logic v, input logic last, input logic [7:0] d);
        in_valid[l]        = v;
        in_last[l]         = last;
        in_data[l*8 +: 8]  = d;
    endtask

    task automatic drain();
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
        m_lock = -1; m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = 1'b0;
        @(posedge clk); #1;
        tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data",  32'(out_data),  32'd0);
        check("reset_out_sel",   32'(out_sel),   32'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // 1. single-beat lanes, all valid: strict rotation at full rate
        for (int n = 0; n < 4; n++) set_lane(n, 1'b1, 1'b1, 8'(8'hA0 + n));
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_sel",  32'(out_sel),  32'(i % 4));
            check("rr_data", 32'(out_data), 32'(8'hA0 + (i % 4)));
        end
        drain();

        // 2. lane 2 three-beat burst with lane 1 waiting
        set_lane(1, 1'b1, 1'b1, 8'h10);
        tick();
        set_lane(1, 1'b0, 1'b1, 8'h10);
        tick();
        set_lane(1, 1'b1, 1'b1, 8'h11);
        for (int b = 0; b < 3; b++) begin
            set_lane(2, 1'b1, (b == 2), 8'(8'h20 + b));
            tick();
            check("burst_sel", 32'(out_sel), 32'd2);
        end
        set_lane(2, 1'b0, 1'b0, 8'h00);
        tick();
        check("after_burst_sel", 32'(out_sel), 32'd1);
        drain();

        // 3. backpressure with 8'h5C held
        set_lane(0, 1'b1, 1'b1, 8'h5C);
        tick();
        set_lane(0, 1'b0, 1'b1, 8'h00);
        set_lane(3, 1'b1, 1'b1, 8'h77);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data",  32'(out_data), 32'h5C);
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("refill_data", 32'(out_data), 32'h77);
        drain();

        // 4. pointer wrap 3 -> 0 -> 1
        set_lane(2, 1'b1, 1'b1, 8'h42);
        tick();
        in_valid = '0;
        set_lane(0, 1'b1, 1'b1, 8'h40);
        set_lane(3, 1'b1, 1'b1, 8'h43);
        tick();
        check("wrap_first", 32'(out_sel), 32'd3);
        tick();
        check("wrap_second", 32'(out_sel), 32'd0);
        set_lane(3, 1'b0, 1'b1, 8'h00);
        set_lane(1, 1'b1, 1'b1, 8'h41);
        tick();
        check("wrap_ptr1", 32'(out_sel), 32'd1);
        drain();

        // 5. reset in the second beat of a lane-0 burst
        set_lane(0, 1'b1, 1'b0, 8'h01);
        tick();
        set_lane(0, 1'b1, 1'b0, 8'h02);
        rst = 1'b1;
        tick();
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        set_lane(0, 1'b0, 1'b0, 8'h00);
        set_lane(1, 1'b1, 1'b1, 8'h51);
        tick();
        check("post_rst_sel", 32'(out_sel), 32'd1);
        drain();

        // 6. gap inside a lane-3 burst with lane 0 pending
        set_lane(0, 1'b1, 1'b1, 8'h60);
        set_lane(3, 1'b1, 1'b0, 8'h63);
        tick();
        check("gap_start", 32'(out_sel), 32'd3);
        tick();
        set_lane(3, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        check("gap_no_grant", 32'(in_ready), 32'b1000);
        set_lane(3, 1'b1, 1'b1, 8'h6F);
        tick();
        check("gap_last_sel", 32'(out_sel), 32'd3);
        set_lane(3, 1'b0, 1'b0, 8'h00);
        tick();
        check("gap_after_sel", 32'(out_sel), 32'd0);
        drain();

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
